// File: rtl/alu_issue_stage_if.sv
// Command, ALU-pin and result signals of the ALU issue stage, bundled for port connection.
// The slave side is the issue stage itself; the master side is its environment (source, ALU, consumer).
interface alu_issue_stage_if #(
    parameter int WIDTH = 128,
    parameter int SHW   = 5,
    parameter int SEQW  = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_opcode;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [SHW-1:0]   in_shift;

    logic [3:0]       alu_opcode;
    logic [WIDTH-1:0] alu_input1;
    logic [WIDTH-1:0] alu_input2;
    logic [SHW-1:0]   alu_shift;
    logic [WIDTH-1:0] alu_result;
    logic             alu_carry;
    logic             alu_zero;
    logic             alu_sign;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_carry;
    logic             out_zero;
    logic             out_sign;
    logic             out_illegal;
    logic [SEQW-1:0]  out_seq;

    modport slave (
        input  in_valid, in_opcode, in_a, in_b, in_shift,
        input  alu_result, alu_carry, alu_zero, alu_sign,
        input  out_ready,
        output in_ready,
        output alu_opcode, alu_input1, alu_input2, alu_shift,
        output out_valid, out_result, out_carry, out_zero, out_sign, out_illegal, out_seq
    );

    modport master (
        output in_valid, in_opcode, in_a, in_b, in_shift,
        output alu_result, alu_carry, alu_zero, alu_sign,
        output out_ready,
        input  in_ready,
        input  alu_opcode, alu_input1, alu_input2, alu_shift,
        input  out_valid, out_result, out_carry, out_zero, out_sign, out_illegal, out_seq
    );
endinterface

// File: rtl/alu_issue_stage.sv
// Issue stage for the combinational ALU: a command FIFO feeds the ALU pins and a valid/ready
// result register captures the ALU outputs with a sequence tag, giving a one-stage pipeline.
module alu_issue_stage #(
    parameter int WIDTH = 128,
    parameter int SHW   = 5,
    parameter int DEPTH = 2,
    parameter int SEQW  = 8
) (
    input logic             clk,
    input logic             rst_n,
    alu_issue_stage_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [3:0]       opcode;
        logic [SHW-1:0]   shift;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } cmd_t;

    cmd_t             mem_q [DEPTH];
    cmd_t             head;
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             full, empty, push, issue;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_result_q, out_result_d;
    logic             out_carry_q, out_carry_d;
    logic             out_zero_q, out_zero_d;
    logic             out_sign_q, out_sign_d;
    logic             out_illegal_q, out_illegal_d;
    logic [SEQW-1:0]  out_seq_q, out_seq_d;
    logic [SEQW-1:0]  seq_q, seq_d;

    // Pointers carry one extra wrap bit so full and empty are distinguishable at equal indices.
    always_comb begin
        empty = (wr_ptr_q == rd_ptr_q);
        full  = (wr_ptr_q == {~rd_ptr_q[AW], rd_ptr_q[AW-1:0]});
        push  = bus.in_valid & ~full;
        issue = ~empty & (~out_valid_q | bus.out_ready);
        head  = mem_q[rd_ptr_q[AW-1:0]];
    end

    // NOTE: every signal gets its hold value first, so no path through this block can infer a latch.
    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        out_valid_d   = out_valid_q;
        out_result_d  = out_result_q;
        out_carry_d   = out_carry_q;
        out_zero_d    = out_zero_q;
        out_sign_d    = out_sign_q;
        out_illegal_d = out_illegal_q;
        out_seq_d     = out_seq_q;
        seq_d         = seq_q;

        if (push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);

        if (issue) begin
            rd_ptr_d    = rd_ptr_q + (AW+1)'(1);
            out_valid_d = 1'b1;
            out_seq_d   = seq_q;
            seq_d       = seq_q + SEQW'(1);
            if (head.opcode[3]) begin
                out_result_d  = '0;
                out_carry_d   = 1'b0;
                out_zero_d    = 1'b1;
                out_sign_d    = 1'b0;
                out_illegal_d = 1'b1;
            end else begin
                out_result_d  = bus.alu_result;
                out_carry_d   = bus.alu_carry;
                out_zero_d    = bus.alu_zero;
                out_sign_d    = bus.alu_sign;
                out_illegal_d = 1'b0;
            end
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            out_valid_q   <= 1'b0;
            out_result_q  <= '0;
            out_carry_q   <= 1'b0;
            out_zero_q    <= 1'b0;
            out_sign_q    <= 1'b0;
            out_illegal_q <= 1'b0;
            out_seq_q     <= '0;
            seq_q         <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            out_valid_q   <= out_valid_d;
            out_result_q  <= out_result_d;
            out_carry_q   <= out_carry_d;
            out_zero_q    <= out_zero_d;
            out_sign_q    <= out_sign_d;
            out_illegal_q <= out_illegal_d;
            out_seq_q     <= out_seq_d;
            seq_q         <= seq_d;
        end
    end

    // NOTE: the storage array has no reset; stale entries are never visible because the head is gated by empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= '{opcode: bus.in_opcode, shift: bus.in_shift,
                                               a: bus.in_a, b: bus.in_b};
    end

    assign bus.in_ready    = ~full;
    assign bus.alu_opcode  = empty ? '0 : head.opcode;
    assign bus.alu_input1  = empty ? '0 : head.a;
    assign bus.alu_input2  = empty ? '0 : head.b;
    assign bus.alu_shift   = empty ? '0 : head.shift;

    assign bus.out_valid   = out_valid_q;
    assign bus.out_result  = out_result_q;
    assign bus.out_carry   = out_carry_q;
    assign bus.out_zero    = out_zero_q;
    assign bus.out_sign    = out_sign_q;
    assign bus.out_illegal = out_illegal_q;
    assign bus.out_seq     = out_seq_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Randomized bench for alu_issue_stage: a stand-in ALU answers the ALU pins, and a queue-based
// model of the FIFO plus holding register predicts every handshake and captured result.
module tb_alu_issue_stage;
    localparam int W     = 128;
    localparam int SHW   = 5;
    localparam int DEPTH = 2;
    localparam int SEQW  = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_issue_stage_if #(.WIDTH(W), .SHW(SHW), .SEQW(SEQW)) bus ();

    alu_issue_stage #(.WIDTH(W), .SHW(SHW), .DEPTH(DEPTH), .SEQW(SEQW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic [3:0]     op;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [SHW-1:0] sh;
    } cmd_t;

    typedef struct {
        logic [W-1:0] r;
        logic         c;
        logic         z;
        logic         s;
        logic         ill;
    } res_t;

    // Stand-in ALU: 0 add, 1 sub (carry = borrow), 2 and, 3 or, 4 nor, 5 xor, 6 shl, 7 shr.
    function automatic res_t ref_alu(input logic [3:0] op, input logic [W-1:0] a,
                                     input logic [W-1:0] b, input logic [SHW-1:0] sh);
        res_t       x;
        logic [W:0] wide;
        x.c = 1'b0;
        x.ill = 1'b0;
        wide = '0;
        case (op)
            4'd0: begin wide = {1'b0, a} + {1'b0, b}; x.r = wide[W-1:0]; x.c = wide[W]; end
            4'd1: begin wide = {1'b0, a} - {1'b0, b}; x.r = wide[W-1:0]; x.c = wide[W]; end
            4'd2: x.r = a & b;
            4'd3: x.r = a | b;
            4'd4: x.r = ~(a | b);
            4'd5: x.r = a ^ b;
            4'd6: x.r = a << sh;
            4'd7: x.r = a >> sh;
            default: begin x.r = ~a; x.c = 1'b1; end
        endcase
        x.z = (x.r == '0);
        x.s = x.r[W-1];
        return x;
    endfunction

    function automatic res_t expect_res(input cmd_t c);
        res_t x;
        if (c.op >= 4'd8) begin
            x.r = '0; x.c = 1'b0; x.z = 1'b1; x.s = 1'b0; x.ill = 1'b1;
        end else begin
            x = ref_alu(c.op, c.a, c.b, c.sh);
        end
        return x;
    endfunction

    res_t alu_x;
    assign alu_x          = ref_alu(bus.alu_opcode, bus.alu_input1, bus.alu_input2, bus.alu_shift);
    assign bus.alu_result = alu_x.r;
    assign bus.alu_carry  = alu_x.c;
    assign bus.alu_zero   = alu_x.z;
    assign bus.alu_sign   = alu_x.s;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: queue of buffered commands plus the one held result.
    cmd_t        fq[$];
    bit          hv;
    cmd_t        hc;
    int unsigned hseq;
    int unsigned seq_n;
    int          prev_seq;
    bit          saw_wrap;

    task automatic model_reset();
        fq.delete();
        hv = 1'b0;
        hseq = 0;
        seq_n = 0;
        prev_seq = -1;
    endtask

    task automatic model_edge();
        int sz;
        bit issue, acc;
        cmd_t nc;
        sz    = fq.size();
        issue = (sz > 0) && (!hv || bus.out_ready);
        acc   = bus.in_valid && (sz < DEPTH);
        if (issue) begin
            hc    = fq.pop_front();
            hv    = 1'b1;
            hseq  = seq_n;
            seq_n = (seq_n + 1) % (1 << SEQW);
        end else if (hv && bus.out_ready) begin
            hv = 1'b0;
        end
        if (acc) begin
            nc.op = bus.in_opcode; nc.a = bus.in_a; nc.b = bus.in_b; nc.sh = bus.in_shift;
            fq.push_back(nc);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_edge();
    end

    always @(negedge clk) begin
        if (rst_n) begin
            res_t e;
            check("in_ready", W'(bus.in_ready), W'(fq.size() < DEPTH));
            check("out_valid", W'(bus.out_valid), W'(hv));
            check("alu_opcode", W'(bus.alu_opcode), (fq.size() > 0) ? W'(fq[0].op) : '0);
            check("alu_input1", bus.alu_input1, (fq.size() > 0) ? fq[0].a : '0);
            check("alu_input2", bus.alu_input2, (fq.size() > 0) ? fq[0].b : '0);
            check("alu_shift", W'(bus.alu_shift), (fq.size() > 0) ? W'(fq[0].sh) : '0);
            if (hv) begin
                e = expect_res(hc);
                check("out_result", bus.out_result, e.r);
                check("out_carry", W'(bus.out_carry), W'(e.c));
                check("out_zero", W'(bus.out_zero), W'(e.z));
                check("out_sign", W'(bus.out_sign), W'(e.s));
                check("out_illegal", W'(bus.out_illegal), W'(e.ill));
                check("out_seq", W'(bus.out_seq), W'(hseq));
                if (bus.out_ready) begin
                    if (prev_seq == 255 && bus.out_seq == 0) saw_wrap = 1'b1;
                    prev_seq = int'(bus.out_seq);
                end
            end
        end
    end

    bit rand_ready = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input cmd_t c);
        bit r;
        bit done;
        done = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_opcode = c.op; bus.in_a = c.a; bus.in_b = c.b; bus.in_shift = c.sh;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            r = bus.in_ready;
            tick();
            if (r) begin
                done = 1'b1;
                break;
            end
        end
        bus.in_valid = 1'b0;
        if (!done) check("send_timeout", W'(done), W'(1));
    endtask

    function automatic cmd_t rand_cmd(input bit allow_illegal);
        cmd_t c;
        c.op = allow_illegal ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 7));
        c.a  = {$urandom, $urandom, $urandom, $urandom};
        c.b  = ($urandom_range(0, 3) == 0) ? c.a : {$urandom, $urandom, $urandom, $urandom};
        c.sh = SHW'($urandom);
        return c;
    endfunction

    function automatic cmd_t mk(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        cmd_t c;
        c.op = op; c.a = a; c.b = b; c.sh = '0;
        return c;
    endfunction

    initial begin
        bus.in_valid = 1'b0; bus.in_opcode = '0; bus.in_a = '0; bus.in_b = '0; bus.in_shift = '0;
        bus.out_ready = 1'b0;
        saw_wrap = 1'b0;
        #12;
        check("rst_out_valid", W'(bus.out_valid), '0);
        check("rst_in_ready", W'(bus.in_ready), W'(1));
        check("rst_out_result", bus.out_result, '0);
        check("rst_out_seq", W'(bus.out_seq), '0);
        check("rst_alu_opcode", W'(bus.alu_opcode), '0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // NOR of zeros: all-ones result one edge after acceptance.
        bus.out_ready = 1'b1;
        send(mk(4'd4, '0, '0));
        check("lat_pre_valid", W'(bus.out_valid), '0);
        tick();
        check("nor_valid", W'(bus.out_valid), W'(1));
        check("nor_result", bus.out_result, {W{1'b1}});
        check("nor_sign", W'(bus.out_sign), W'(1));
        check("nor_zero", W'(bus.out_zero), '0);
        check("nor_seq", W'(bus.out_seq), '0);
        idle(2);

        for (int i = 0; i < 4; i++) send(rand_cmd(1'b0));
        idle(4);

        // Backpressure: three commands fill holding register plus FIFO.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(rand_cmd(1'b0));
        check("bp_in_ready", W'(bus.in_ready), '0);
        check("bp_out_valid", W'(bus.out_valid), W'(1));
        idle(2);
        bus.out_ready = 1'b1;
        idle(5);

        send(mk(4'd12, W'(5), '0));
        tick();
        check("ill_result", bus.out_result, '0);
        check("ill_zero", W'(bus.out_zero), W'(1));
        check("ill_flag", W'(bus.out_illegal), W'(1));
        idle(2);

        rand_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) != 0) send(rand_cmd(1'b1));
            else                           tick();
        end
        rand_ready = 1'b0;
        bus.out_ready = 1'b1;
        idle(8);
        check("seq_wrap", W'(saw_wrap), W'(1));

        // Asynchronous reset with full FIFO and held result.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(rand_cmd(1'b0));
        check("pre_rst_in_ready", W'(bus.in_ready), '0);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", W'(bus.out_valid), '0);
        check("mid_rst_in_ready", W'(bus.in_ready), W'(1));
        check("mid_rst_alu_opcode", W'(bus.alu_opcode), '0);
        check("mid_rst_out_seq", W'(bus.out_seq), '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        send(mk(4'd0, W'(7), W'(9)));
        tick();
        check("post_rst_valid", W'(bus.out_valid), W'(1));
        check("post_rst_result", bus.out_result, W'(16));
        check("post_rst_seq", W'(bus.out_seq), '0);
        idle(3);
        check("final_idle", W'(bus.out_valid), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
